// File: rtl/cylon_btn_conditioner.sv
// Purpose : synchronise, debounce and auto-repeat the raw board buttons feeding the cylon control FSM.
// Latency : raw change first sampled at edge 0 appears on level/press/release at edge DEBOUNCE_CYCLES+1.
// Backpr. : none; strobes are single-cycle pulses with no handshake, every button runs independently.
module cylon_btn_conditioner #(
    parameter int unsigned NUM_BTN             = 4,
    parameter logic [28:0] DEBOUNCE_CYCLES     = 29'd1000000,
    parameter logic [28:0] REPEAT_DELAY_CYCLES = 29'd50000000,
    parameter logic [28:0] REPEAT_RATE_CYCLES  = 29'd10000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    // Terminal counts; counters compare for equality and clear, so they never wrap.
    localparam logic [28:0] DB_LAST    = DEBOUNCE_CYCLES - 29'd1;
    localparam logic [28:0] DELAY_LAST = REPEAT_DELAY_CYCLES - 29'd1;
    localparam logic [28:0] RATE_LAST  = REPEAT_RATE_CYCLES - 29'd1;
    localparam bit          REPEAT_EN  = (REPEAT_DELAY_CYCLES != 29'd0);

    typedef enum logic [1:0] {
        REP_IDLE  = 2'd0,
        REP_DELAY = 2'd1,
        REP_RATE  = 2'd2
    } rep_state_t;

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    // Two-flop synchroniser; only the second stage is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        logic        level_q, level_d;
        logic        press_q, press_d;
        logic        release_q, release_d;
        logic        repeat_q, repeat_d;
        logic [28:0] db_cnt_q, db_cnt_d;
        logic [28:0] rep_cnt_q, rep_cnt_d;
        rep_state_t  rep_st_q, rep_st_d;

        // Debounce: accept the synchronised value only after it differs from the level for DEBOUNCE_CYCLES cycles.
        always_comb begin
            level_d   = level_q;
            db_cnt_d  = db_cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (sync2_q[g] == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_d   = sync2_q[g];
                db_cnt_d  = '0;
                press_d   = sync2_q[g];
                release_d = ~sync2_q[g];
            end else begin
                db_cnt_d = db_cnt_q + 29'd1;
            end
        end

        // Repeat FSM: release wins over everything so a repeat never coincides with a release.
        always_comb begin
            rep_st_d  = rep_st_q;
            rep_cnt_d = rep_cnt_q;
            repeat_d  = 1'b0;
            if (release_d) begin
                rep_st_d  = REP_IDLE;
                rep_cnt_d = '0;
            end else begin
                case (rep_st_q)
                    REP_IDLE: begin
                        if (press_d && REPEAT_EN) begin
                            rep_st_d  = REP_DELAY;
                            rep_cnt_d = '0;
                        end
                    end
                    REP_DELAY: begin
                        if (rep_cnt_q == DELAY_LAST) begin
                            repeat_d  = 1'b1;
                            rep_cnt_d = '0;
                            rep_st_d  = REP_RATE;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 29'd1;
                        end
                    end
                    REP_RATE: begin
                        if (rep_cnt_q == RATE_LAST) begin
                            repeat_d  = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 29'd1;
                        end
                    end
                    default: begin
                        rep_st_d  = REP_IDLE;
                        rep_cnt_d = '0;
                    end
                endcase
            end
        end

        // Per-button state and registered outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                db_cnt_q  <= '0;
                rep_cnt_q <= '0;
                rep_st_q  <= REP_IDLE;
            end else begin
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
                db_cnt_q  <= db_cnt_d;
                rep_cnt_q <= rep_cnt_d;
                rep_st_q  <= rep_st_d;
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
        assign btn_repeat[g]  = repeat_q;
    end

endmodule

// File: tb/tb_cylon_btn_conditioner.sv
// Purpose : self-checking bench for cylon_btn_conditioner with small debounce/repeat counts.
// Latency : checks outputs on the falling edge after each rising edge.
// Backpr. : n/a.
module tb_cylon_btn_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int NT = 51;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

    cylon_btn_conditioner #(
        .NUM_BTN            (4),
        .DEBOUNCE_CYCLES    (29'd4),
        .REPEAT_DELAY_CYCLES(29'd10),
        .REPEAT_RATE_CYCLES (29'd3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_on = 0;

    function automatic logic [15:0] outs();
        return {btn_level, btn_press, btn_release, btn_repeat};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a change is accepted once the last DB synchronised samples all
    // differ from the current level; repeats follow from the age since the press.
    logic [3:0] m_s1, m_s2, m_level, m_press, m_rel, m_rep;
    logic [3:0] win_q[$];
    int         edge_n;
    int         press_at[4];

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0;
        m_press = '0; m_rel = '0; m_rep = '0;
        win_q.delete();
    endfunction

    function automatic void model_edge(input logic [3:0] raw);
        logic [3:0] cur, nl;
        bit         alldiff;
        int         age;
        cur = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        win_q.push_back(cur);
        if (win_q.size() > DB) void'(win_q.pop_front());
        nl = m_level;
        m_press = '0; m_rel = '0; m_rep = '0;
        for (int b = 0; b < 4; b++) begin
            alldiff = (win_q.size() == DB);
            for (int k = 0; k < win_q.size(); k++)
                if (win_q[k][b] == m_level[b]) alldiff = 0;
            if (alldiff) begin
                nl[b] = ~m_level[b];
                if (nl[b]) begin
                    m_press[b] = 1'b1;
                    press_at[b] = edge_n;
                end else begin
                    m_rel[b] = 1'b1;
                end
            end else if (m_level[b]) begin
                age = edge_n - press_at[b];
                if (age >= RD && (age - RD) % RR == 0) m_rep[b] = 1'b1;
            end
        end
        m_level = nl;
        edge_n++;
    endfunction

    // Drive one raw value, clock it in, check on the falling edge.
    task automatic step(input logic [3:0] raw);
        btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        @(negedge clk);
        if (model_on) chk("model", outs(), {m_level, m_press, m_rel, m_rep});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_clear", outs(), 16'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hold", outs(), 16'h0);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0] raw;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rpt;
    } vec_t;

    vec_t tab [NT];

    initial begin
        int press_n;
        int hold [4];
        logic [3:0] cur;

        // Vector i is applied before edge i after reset release; expectations hold after that edge.
        for (int i = 0; i < NT; i++) tab[i] = '0;
        for (int i = 0; i < 20; i++) tab[i].raw = 4'b0001;       // press, hold, repeat
        for (int i = 5; i < 25; i++) tab[i].level = 4'b0001;
        tab[5].press  = 4'b0001;
        tab[15].rpt   = 4'b0001;
        tab[18].rpt   = 4'b0001;
        tab[21].rpt   = 4'b0001;
        tab[24].rpt   = 4'b0001;
        tab[25].rel   = 4'b0001;                                 // raw low at 20 -> release at 25
        for (int i = 28; i < 31; i++) tab[i].raw = 4'b0001;      // 3-cycle glitch: ignored
        tab[40].raw = 4'b0001;                                   // 1,1,0,1,1,...
        tab[41].raw = 4'b0001;
        for (int i = 43; i < NT; i++) tab[i].raw = 4'b0001;
        for (int i = 48; i < NT; i++) tab[i].level = 4'b0001;
        tab[48].press = 4'b0001;

        rst = 1'b0;
        btn_raw = '0;
        edge_n = 0;
        #2;
        do_reset();

        for (int i = 0; i < NT; i++) begin
            step(tab[i].raw);
            chk($sformatf("vec%0d", i), outs(),
                {tab[i].level, tab[i].press, tab[i].rel, tab[i].rpt});
        end

        // Reset while btnL is held in the rate phase.
        do_reset();
        model_on = 1;
        for (int n = 0; n < 20; n++) step(4'b0100);
        rst = 1'b1;
        #1;
        chk("rst_in_rate", outs(), 16'h0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_no_strobe", outs(), 16'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        press_n = 0;
        for (int n = 1; n <= 12; n++) begin
            step(4'b0100);
            if (press_n == 0 && btn_press[2]) press_n = n;
        end
        chk("press_after_rst", 16'(press_n), 16'(DB + 2));

        // Two buttons raised together strobe together.
        do_reset();
        for (int n = 0; n < DB + 2; n++) step(4'b1001);
        chk("dual_press", {12'h0, btn_press}, {12'h0, 4'b1001});

        // Randomised bouncing buttons against the model.
        do_reset();
        cur = '0;
        for (int b = 0; b < 4; b++) hold[b] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    cur[b] = 1'($urandom_range(0, 1));
                    hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 40));
                end else begin
                    hold[b]--;
                end
            end
            if (cyc % 997 == 500) do_reset();
            step(cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
